ahb_mtx_in_stg: RTL and testbench



---
 rtl/ahb_mtx_in_stg.sv | 127 ++++++++++++
 tb/tb_ahb_mtx_in_stg.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_mtx_in_stg.sv
// AHB bus-matrix input stage for one slave port: holds a transfer while the
// decoder's output stage is not granted and returns the data-phase response.
module ahb_mtx_in_stg #(
    parameter int AUSER_W = 32
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic               HSELS,
    input  logic [31:0]        HADDRS,
    input  logic [1:0]         HTRANSS,
    input  logic               HWRITES,
    input  logic [2:0]         HSIZES,
    input  logic [2:0]         HBURSTS,
    input  logic [3:0]         HPROTS,
    input  logic               HMASTLOCKS,
    input  logic [AUSER_W-1:0] HAUSERS,
    input  logic               HREADYS,
    input  logic               active_dec,
    input  logic               readyout_dec,
    input  logic [1:0]         resp_dec,
    output logic               sel_dec,
    output logic [21:0]        decode_addr_dec,
    output logic [1:0]         trans_dec,
    output logic [31:0]        addr_op,
    output logic               write_op,
    output logic [2:0]         size_op,
    output logic [2:0]         burst_op,
    output logic [3:0]         prot_op,
    output logic               lock_op,
    output logic [AUSER_W-1:0] auser_op,
    output logic               ready_dec,
    output logic               HREADYOUTS,
    output logic [1:0]         HRESPS
);

    logic               hold_valid_reg, hold_valid_next;
    logic [31:0]        hold_addr_reg;
    logic [1:0]         hold_trans_reg;
    logic               hold_write_reg;
    logic [2:0]         hold_size_reg;
    logic [2:0]         hold_burst_reg;
    logic [3:0]         hold_prot_reg;
    logic               hold_lock_reg;
    logic [AUSER_W-1:0] hold_auser_reg;
    logic               dph_reg, dph_next;

    logic new_tran;
    logic hold_load;
    logic hold_clr;
    logic accept;

    // Only NONSEQ/SEQ are worth holding; IDLE/BUSY need no grant.
    assign new_tran  = HSELS & HTRANSS[1] & HREADYS;
    assign hold_load = new_tran & ~active_dec & ~hold_valid_reg;
    assign hold_clr  = hold_valid_reg & active_dec;

    always_comb begin
        if (hold_valid_reg) begin
            addr_op   = hold_addr_reg;
            trans_dec = hold_trans_reg;
            write_op  = hold_write_reg;
            size_op   = hold_size_reg;
            burst_op  = hold_burst_reg;
            prot_op   = hold_prot_reg;
            lock_op   = hold_lock_reg;
            auser_op  = hold_auser_reg;
        end else begin
            addr_op   = HADDRS;
            trans_dec = HTRANSS;
            write_op  = HWRITES;
            size_op   = HSIZES;
            burst_op  = HBURSTS;
            prot_op   = HPROTS;
            lock_op   = HMASTLOCKS;
            auser_op  = HAUSERS;
        end
    end

    assign decode_addr_dec = addr_op[31:10];
    assign sel_dec         = hold_valid_reg | HSELS;
    // A held transfer is re-presented as if the bus were ready every cycle.
    assign ready_dec       = hold_valid_reg ? 1'b1 : HREADYS;
    assign accept          = ready_dec & sel_dec & trans_dec[1] & active_dec;

    always_comb begin
        hold_valid_next = hold_valid_reg;
        if (hold_clr) begin
            hold_valid_next = 1'b0;
        end else if (hold_load) begin
            hold_valid_next = 1'b1;
        end
        dph_next = ready_dec ? accept : dph_reg;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            hold_valid_reg <= 1'b0;
            dph_reg        <= 1'b0;
            hold_addr_reg  <= '0;
            hold_trans_reg <= '0;
            hold_write_reg <= 1'b0;
            hold_size_reg  <= '0;
            hold_burst_reg <= '0;
            hold_prot_reg  <= '0;
            hold_lock_reg  <= 1'b0;
            hold_auser_reg <= '0;
        end else begin
            hold_valid_reg <= hold_valid_next;
            dph_reg        <= dph_next;
            if (hold_load) begin
                hold_addr_reg  <= HADDRS;
                hold_trans_reg <= HTRANSS;
                hold_write_reg <= HWRITES;
                hold_size_reg  <= HSIZES;
                hold_burst_reg <= HBURSTS;
                hold_prot_reg  <= HPROTS;
                hold_lock_reg  <= HMASTLOCKS;
                hold_auser_reg <= HAUSERS;
            end
        end
    end

    // The stall while holding masks any downstream response.
    assign HREADYOUTS = hold_valid_reg ? 1'b0 : (dph_reg ? readyout_dec : 1'b1);
    assign HRESPS     = (dph_reg & ~hold_valid_reg) ? resp_dec : 2'b00;

endmodule

// File: tb/tb_ahb_mtx_in_stg.sv
// Bench for ahb_mtx_in_stg: directed scenarios with literal expectations, then
// randomized legal-master traffic checked every cycle against a transfer-level model.
module tb_ahb_mtx_in_stg;

    localparam int AUSER_W = 32;

    logic               HCLK;
    logic               HRESET;
    logic               HSELS;
    logic [31:0]        HADDRS;
    logic [1:0]         HTRANSS;
    logic               HWRITES;
    logic [2:0]         HSIZES;
    logic [2:0]         HBURSTS;
    logic [3:0]         HPROTS;
    logic               HMASTLOCKS;
    logic [AUSER_W-1:0] HAUSERS;
    logic               HREADYS;
    logic               active_dec;
    logic               readyout_dec;
    logic [1:0]         resp_dec;
    logic               sel_dec;
    logic [21:0]        decode_addr_dec;
    logic [1:0]         trans_dec;
    logic [31:0]        addr_op;
    logic               write_op;
    logic [2:0]         size_op;
    logic [2:0]         burst_op;
    logic [3:0]         prot_op;
    logic               lock_op;
    logic [AUSER_W-1:0] auser_op;
    logic               ready_dec;
    logic               HREADYOUTS;
    logic [1:0]         HRESPS;

    ahb_mtx_in_stg #(.AUSER_W(AUSER_W)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSELS(HSELS), .HADDRS(HADDRS),
        .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
        .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS), .HAUSERS(HAUSERS), .HREADYS(HREADYS),
        .active_dec(active_dec), .readyout_dec(readyout_dec), .resp_dec(resp_dec),
        .sel_dec(sel_dec), .decode_addr_dec(decode_addr_dec), .trans_dec(trans_dec),
        .addr_op(addr_op), .write_op(write_op), .size_op(size_op), .burst_op(burst_op),
        .prot_op(prot_op), .lock_op(lock_op), .auser_op(auser_op), .ready_dec(ready_dec),
        .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct packed {
        logic [31:0]        addr;
        logic [1:0]         trans;
        logic               write;
        logic [2:0]         size;
        logic [2:0]         burst;
        logic [3:0]         prot;
        logic               lock;
        logic [AUSER_W-1:0] auser;
    } xfer_t;

    int total = 0;
    int bad   = 0;
    int n_xfer = 0;

    // Transfer-level model: a pending (held) transfer, an open data phase,
    // and a queue of transfers issued by the master but not yet accepted.
    logic  m_valid = 1'b0;
    logic  m_hold  = 1'b0;
    logic  m_dph   = 1'b0;
    xfer_t m_h;
    xfer_t sb_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge HCLK) begin
        xfer_t cur, eo, fr;
        logic  e_sel, e_rdy, e_acc, e_hro, ntr;
        logic [1:0] e_resp;
        cur = '{HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS, HAUSERS};
        ntr = HSELS & HTRANSS[1] & HREADYS;
        e_rdy = 1'b0;
        e_acc = 1'b0;
        if (m_valid) begin
            eo     = m_hold ? m_h : cur;
            e_sel  = m_hold | HSELS;
            e_rdy  = m_hold ? 1'b1 : HREADYS;
            e_acc  = e_rdy & e_sel & eo.trans[1] & active_dec;
            e_hro  = m_hold ? 1'b0 : (m_dph ? readyout_dec : 1'b1);
            e_resp = (m_dph && !m_hold) ? resp_dec : 2'b00;
            chk("sel_dec", 64'(sel_dec), 64'(e_sel));
            chk("decode_addr", 64'(decode_addr_dec), 64'(eo.addr[31:10]));
            chk("trans_dec", 64'(trans_dec), 64'(eo.trans));
            chk("ctrl_op", 64'({write_op, size_op, burst_op, prot_op, lock_op}),
                64'({eo.write, eo.size, eo.burst, eo.prot, eo.lock}));
            chk("addr_op", 64'(addr_op), 64'(eo.addr));
            chk("auser_op", 64'(auser_op), 64'(eo.auser));
            chk("ready_dec", 64'(ready_dec), 64'(e_rdy));
            chk("hreadyout", 64'(HREADYOUTS), 64'(e_hro));
            chk("hresp", 64'(HRESPS), 64'(e_resp));
            if (!HRESET) begin
                if (ntr && !m_hold) sb_q.push_back(cur);
                if (e_acc) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_underflow", 64'(1), 64'(0));
                    end else begin
                        fr = sb_q.pop_front();
                        chk("sb_xfer", 64'({addr_op, write_op, trans_dec}),
                            64'({fr.addr, fr.write, fr.trans}));
                        n_xfer++;
                        $display("xfer %0d addr=%h write=%b trans=%b", n_xfer, addr_op, write_op, trans_dec);
                    end
                end
            end
        end
        if (HRESET) begin
            m_valid = 1'b1;
            m_hold  = 1'b0;
            m_dph   = 1'b0;
            m_h     = '0;
            sb_q.delete();
        end else if (m_valid) begin
            if (m_hold && active_dec) begin
                m_hold = 1'b0;
            end else if (ntr && !active_dec && !m_hold) begin
                m_hold = 1'b1;
                m_h    = cur;
            end
            if (e_rdy) m_dph = e_acc;
        end
    end

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drv(input logic s, input logic [1:0] t, input logic [31:0] a,
                       input logic r, input logic act, input logic ro, input logic [1:0] rs);
        HSELS        = s;
        HTRANSS      = t;
        HADDRS       = a;
        HREADYS      = r;
        active_dec   = act;
        readyout_dec = ro;
        resp_dec     = rs;
    endtask

    initial begin
        HRESET = 1'b1;
        HWRITES = 1'b1; HSIZES = 3'd2; HBURSTS = 3'd0; HPROTS = 4'h3;
        HMASTLOCKS = 1'b0; HAUSERS = 32'hA5A5_0001;
        drv(0, 2'b00, 32'h0, 1, 0, 1, 2'b00);
        cyc();
        cyc();
        HRESET = 1'b0;
        #2;
        chk("rst_hreadyout", 64'(HREADYOUTS), 64'(1));
        chk("rst_hresp", 64'(HRESPS), 64'(0));
        chk("rst_sel", 64'(sel_dec), 64'(0));

        // Pass-through with two data-phase wait states
        cyc(); drv(1, 2'b10, 32'h0000_1000, 1, 1, 1, 2'b00); #2;
        chk("tp1_decode", 64'(decode_addr_dec), 64'(22'h000004));
        chk("tp1_trans", 64'(trans_dec), 64'(2'b10));
        cyc(); drv(0, 2'b00, 32'h0, 0, 1, 0, 2'b00); #2;
        chk("tp1_wait0", 64'(HREADYOUTS), 64'(0));
        cyc(); drv(0, 2'b00, 32'h0, 0, 1, 0, 2'b00); #2;
        chk("tp1_wait1", 64'(HREADYOUTS), 64'(0));
        cyc(); drv(0, 2'b00, 32'h0, 1, 1, 1, 2'b00); #2;
        chk("tp1_done", 64'(HREADYOUTS), 64'(1));
        cyc(); drv(0, 2'b00, 32'h0, 1, 1, 0, 2'b00); #2;
        chk("tp1_closed", 64'(HREADYOUTS), 64'(1));

        // Hold for three cycles; master drops HSELS, then drives a stalled NONSEQ
        cyc(); drv(1, 2'b10, 32'h0000_2000, 1, 0, 1, 2'b00);
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (i < 2) drv(0, 2'b00, 32'hDEAD_0000, 0, 0, 0, 2'b00);
            else       drv(1, 2'b10, 32'h0000_3000, 0, 1, 0, 2'b00);
            #2;
            chk("tp2_addr", 64'(addr_op), 64'(32'h0000_2000));
            chk("tp2_stall", 64'(HREADYOUTS), 64'(0));
            chk("tp2_sel", 64'(sel_dec), 64'(1));
        end
        cyc(); drv(1, 2'b10, 32'h0000_3000, 0, 1, 0, 2'b00); #2;
        chk("tp2_dph_wait", 64'(HREADYOUTS), 64'(0));
        chk("tp2_no_reload", 64'(addr_op), 64'(32'h0000_3000));
        cyc(); drv(1, 2'b10, 32'h0000_3000, 1, 1, 1, 2'b00); #2;
        chk("tp2_dph_done", 64'(HREADYOUTS), 64'(1));
        cyc(); drv(0, 2'b00, 32'h0, 1, 1, 1, 2'b00);

        // Two-cycle ERROR response
        cyc(); drv(1, 2'b10, 32'h0000_4000, 1, 1, 1, 2'b00);
        cyc(); drv(0, 2'b00, 32'h0, 0, 1, 0, 2'b01); #2;
        chk("tp4_err1_resp", 64'(HRESPS), 64'(2'b01));
        chk("tp4_err1_rdy", 64'(HREADYOUTS), 64'(0));
        cyc(); drv(0, 2'b00, 32'h0, 1, 1, 1, 2'b01); #2;
        chk("tp4_err2_resp", 64'(HRESPS), 64'(2'b01));
        chk("tp4_err2_rdy", 64'(HREADYOUTS), 64'(1));
        cyc(); drv(0, 2'b00, 32'h0, 1, 1, 1, 2'b00);

        // Back-to-back SEQ, zero wait states
        cyc(); drv(1, 2'b10, 32'h0000_5000, 1, 1, 1, 2'b00);
        for (int i = 0; i < 4; i++) begin
            cyc(); drv(1, 2'b11, 32'h0000_5004 + 32'(4 * i), 1, 1, 1, 2'b00); #2;
            chk("tp3_rdy", 64'(HREADYOUTS), 64'(1));
            chk("tp3_addr", 64'(addr_op), 64'(32'h0000_5004 + 32'(4 * i)));
        end
        cyc(); drv(0, 2'b00, 32'h0, 1, 1, 1, 2'b00);

        // Reset while a transfer is held
        cyc(); drv(1, 2'b10, 32'h0000_6000, 1, 0, 1, 2'b00);
        cyc(); drv(0, 2'b00, 32'h0, 0, 0, 0, 2'b01); HRESET = 1'b1; #2;
        chk("tp5_holding", 64'(HREADYOUTS), 64'(0));
        cyc(); HRESET = 1'b0; drv(0, 2'b00, 32'h0, 1, 0, 0, 2'b01); #2;
        chk("tp5_rdy", 64'(HREADYOUTS), 64'(1));
        chk("tp5_resp", 64'(HRESPS), 64'(0));
        chk("tp5_sel", 64'(sel_dec), 64'(0));

        // IDLE/BUSY without grant are never held
        cyc(); drv(1, 2'b00, 32'h0000_7000, 1, 0, 1, 2'b00); #2;
        chk("tp6_idle", 64'(HREADYOUTS), 64'(1));
        cyc(); drv(1, 2'b01, 32'h0000_7004, 1, 0, 1, 2'b00); #2;
        chk("tp6_busy", 64'(HREADYOUTS), 64'(1));
        chk("tp6_addr", 64'(addr_op), 64'(32'h0000_7004));
        cyc(); drv(0, 2'b00, 32'h0, 1, 0, 0, 2'b01); #2;
        chk("tp6_sel", 64'(sel_dec), 64'(0));
        chk("tp6_resp", 64'(HRESPS), 64'(0));

        // Randomized legal-master traffic: HREADYS follows this port's HREADYOUTS
        for (int n = 0; n < 3000; n++) begin
            cyc();
            HRESET       = ($urandom_range(0, 199) == 0);
            HSELS        = ($urandom_range(0, 3) != 0);
            HTRANSS      = 2'($urandom);
            HADDRS       = $urandom & 32'hFFFF_FFFC;
            HWRITES      = 1'($urandom);
            HSIZES       = 3'($urandom);
            HBURSTS      = 3'($urandom);
            HPROTS       = 4'($urandom);
            HMASTLOCKS   = 1'($urandom);
            HAUSERS      = $urandom;
            active_dec   = ($urandom_range(0, 9) < 6);
            readyout_dec = ($urandom_range(0, 9) < 7);
            resp_dec     = 2'($urandom);
            HREADYS      = m_hold ? 1'b0 : (m_dph ? readyout_dec : 1'b1);
        end
        cyc();
        HRESET = 1'b0;
        drv(0, 2'b00, 32'h0, 1, 0, 1, 2'b00);
        #2;
        chk("sb_pending", 64'(sb_q.size()), 64'(m_hold ? 1 : 0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
